// File: rtl/led_pwm.sv
// Multi-channel LED PWM brightness controller with per-channel immediate or linear-fade duty updates.
// Duty changes are applied only at PWM period boundaries, so each period's waveform is glitch-free.
module led_pwm #(
  parameter int CHANNELS   = 3,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int PRESCALE   = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_fade,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic [CHANNELS-1:0]   busy,
  output logic                  period_start
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = '1;

  logic [PRE_W-1:0] pre;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic             tick;
  logic             boundary;

  assign tick     = (pre == PRE_LAST);
  assign boundary = tick && (cnt == CNT_LAST);
  assign cnt_next = tick ? cnt + 1'b1 : cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre          <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      pre          <= tick ? '0 : pre + 1'b1;
      cnt          <= cnt_next;
      period_start <= boundary;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] active_next;
    logic             fade;
    logic             pwm;
    logic             wr_hit;

    // Addresses at or beyond CHANNELS match no channel, so such writes vanish.
    assign wr_hit = wr_en && (wr_addr == ADDR_WIDTH'(gi));

    // The boundary sees the registered target/fade, i.e. the pre-write values.
    always_comb begin
      active_next = active;
      if (boundary) begin
        if (!fade)
          active_next = target;
        else if (active < target)
          active_next = active + 1'b1;
        else if (active > target)
          active_next = active - 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        target <= '0;
        fade   <= 1'b0;
        active <= '0;
        pwm    <= 1'b0;
      end else begin
        if (wr_hit) begin
          target <= wr_data;
          fade   <= wr_fade;
        end
        active <= active_next;
        pwm    <= (cnt_next < active_next);
      end
    end

    assign pwm_out[gi] = pwm;
    assign busy[gi]    = (active != target);
  end

endmodule

// File: doc/led_pwm.md
# led_pwm

Parametrised multi-channel PWM brightness controller for the board's status LEDs, replacing the on/off drive of individual `io_port` bits. Sits between the `computer` I/O write path and the LED driver: software writes a per-channel duty (immediately or as a linear fade), and the block emits glitch-free PWM waveforms on `pwm_out`. All activity is in the video dot-clock domain.

## Interface
Parameters:
- `CHANNELS`, 3, number of PWM channels (1..16).
- `WIDTH`, 8, duty/counter resolution in bits (2..12).
- `ADDR_WIDTH`, 2, width of `wr_addr`; 2**ADDR_WIDTH >= CHANNELS.
- `PRESCALE`, 256, clocks per PWM counter step (>= 1).

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `wr_en` input 1: write strobe, one write per high cycle.
- `wr_addr` input ADDR_WIDTH: target channel.
- `wr_data` input WIDTH: new duty target.
- `wr_fade` input 1: 0 = immediate set, 1 = fade toward target.
- `pwm_out` output CHANNELS: registered PWM outputs.
- `busy` output CHANNELS: high while the channel's active duty != its target.
- `period_start` output 1: one-cycle pulse at each PWM period start.

## Operation
- Prescaler `pre` counts 0..PRESCALE-1 and wraps; `tick` is true on the cycle `pre == PRESCALE-1`. PRESCALE=1 means `tick` every cycle.
- PWM counter `cnt` (WIDTH bits) increments on `tick` and wraps 2**WIDTH-1 -> 0. A `boundary` is a `tick` while `cnt == 2**WIDTH-1`.
- Per channel: `target[i]` and `active[i]`, each WIDTH bits.
- Write (`wr_en`, `wr_addr < CHANNELS`): `target[wr_addr] <= wr_data`; the mode bit is stored per channel as `fade[i] <= wr_fade`. Writes with `wr_addr >= CHANNELS` are ignored with no side effects.
- On `boundary`, for each channel:
  - immediate mode: `active <= target`.
  - fade mode: `active` steps by +1 if below `target`, by -1 if above, and is unchanged if equal. One step per period; no wrap or overshoot.
- `active` changes only at boundaries, so every period's duty is constant (no mid-period glitches).
- Write and boundary in the same cycle: the boundary uses the pre-write `target`/`fade`; the new write takes effect from the next boundary.
- Multiple writes to one channel within a period: the last one wins.
- Output: `pwm_out[i] <= (cnt_next < active_next[i])`, registered, where `_next` means the values being loaded this cycle.
  - duty 0 is constant low.
  - duty d gives d high steps per 2**WIDTH steps.
  - max duty is (2**WIDTH-1)/2**WIDTH; the output is never constant high.
- `busy[i] = (active[i] != target[i])`, combinational from registers.
- `period_start` is registered; it is high for exactly the one cycle after the boundary, i.e. while `cnt == 0 && pre == 0`.

## Timing
- Reset (async assert, sync release):
  - `pre`, `cnt`, all `target`, all `active` and all `fade` = 0.
  - `pwm_out` = 0, `busy` = 0, `period_start` = 0.
- After deassertion, the first boundary occurs PRESCALE * 2**WIDTH cycles later.
- Write-to-output latency, immediate mode: `busy` rises the cycle after the write and falls the cycle after the next boundary. The new duty is visible on `pwm_out` from the first cycle of the following period, aligned with `period_start`.
- Fade from a to b takes |a-b| periods. `busy` deasserts in the cycle after the boundary where `active` reaches `b`.
- Reset mid-fade: state clears immediately and `pwm_out` drops to 0 asynchronously.
- `pwm_out` edges occur only on cycles following a `tick`.

## Test plan
- Reset: hold `reset_n` = 0, toggle inputs -> all outputs 0. Release -> `period_start` first pulses after PRESCALE * 2**WIDTH cycles.
- Immediate duty (WIDTH=4, PRESCALE=2): write ch0 = 5 mid-period -> unchanged until the boundary, then exactly 10 high cycles per 32-cycle period. Duty 0 gives constant low; duty 15 gives 30 high / 2 low.
- Fade: ch1 active 2, write target 6 with `wr_fade` = 1 -> `active` steps 3, 4, 5, 6 over 4 periods. `busy[1]` is high for exactly that span, then falls; fade down 6 -> 2 mirrors this.
- Write on boundary cycle: assert `wr_en` exactly on a boundary -> the old value is used for that period and the new value applies one period later. Two writes in one period -> only the last applies.
- Invalid address (CHANNELS=3, `wr_addr` = 3) -> no `target`/`busy` change on any channel.
- Reset mid-fade: assert `reset_n` during the fade -> `pwm_out`/`busy` go to 0 asynchronously; after release, all channels stay at duty 0.
